spgd_dither_sequencer: RTL and testbench

Sequencer for one SPGD dither iteration around the ADC averager. It applies a +delta perturbation, lets the optics settle, and runs one averaging window to capture J+. It then does the same with a -delta perturbation to capture J-, and emits the signed metric difference dJ = J+ - J- to the gradient/update stage. It owns the averager's reset line and is the only block that starts or stops averaging windows.

---
 rtl/spgd_pkg.sv | 8 +
 rtl/spgd_wait_timer.sv | 18 +
 rtl/spgd_dither_sequencer.sv | 111 +++++++++++
 tb/tb_spgd_dither_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spgd_pkg.sv
// spgd_pkg: shared state encoding and counter widths for the SPGD dither sequencer
package spgd_pkg;
  typedef enum logic [2:0] {IDLE, P_SETTLE, P_AVG, M_SETTLE, M_AVG, DIFF} state_t;
  localparam int SETTLE_W = 16;
  localparam int TMO_W = 16;
  localparam int TMR_W = SETTLE_W > TMO_W ? SETTLE_W : TMO_W;
  localparam int ITER_W = 16;
endpackage

// File: rtl/spgd_wait_timer.sv
// spgd_wait_timer: loadable down-counter, TC high while the count is zero
module spgd_wait_timer #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] LOAD_VAL,
  output logic         TC
);
  logic [W-1:0] cnt;
  // load wins; otherwise count down and park at zero
  always_ff @(posedge CLK)
    if (RST) cnt <= '0;
    else if (LOAD) cnt <= LOAD_VAL;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign TC = cnt == '0;
endmodule

// File: rtl/spgd_dither_sequencer.sv
// spgd_dither_sequencer: +delta/-delta dither around the averager, emits dJ = J+ - J-
module spgd_dither_sequencer
  import spgd_pkg::*;
#(
  parameter int ADC_WIDTH = 12,
  parameter int SETTLE_CYCLES = 256,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     STOP,
  output logic                     AVG_RST,
  input  logic                     AVG_DONE,
  input  logic signed [ADC_WIDTH:0]   AVG_DATA,
  output logic                     PERT_EN,
  output logic                     PERT_SIGN,
  output logic signed [ADC_WIDTH:0]   J_PLUS,
  output logic signed [ADC_WIDTH:0]   J_MINUS,
  output logic signed [ADC_WIDTH+1:0] DJ,
  output logic                     DJ_VALID,
  output logic                     BUSY,
  output logic                     TIMEOUT_ERR,
  output logic [ITER_W-1:0]        ITER_COUNT
);
  // the timer holds N-1 on entry so TC rises after exactly N cycles in the state
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LD = TMR_W'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic stop_q, tc, in_settle, in_avg, tmr_load;
  logic [TMR_W-1:0] tmr_val;
  // reload the shared timer on every entry into a settle or averaging state
  always_comb begin
    in_settle = state == P_SETTLE || state == M_SETTLE;
    in_avg = state == P_AVG || state == M_AVG;
    tmr_load = (state == IDLE && START) || (in_settle && tc) || (in_avg && AVG_DONE) || (state == DIFF && !stop_q);
    tmr_val = in_settle ? TMO_LD : SETTLE_LD;
  end
  spgd_wait_timer #(.W(TMR_W)) u_timer (
    .CLK(CLK),
    .RST(RST),
    .LOAD(tmr_load),
    .LOAD_VAL(tmr_val),
    .TC(tc)
  );
  // sequencer FSM with registered outputs, metric capture and iteration count
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      stop_q <= 1'b0;
      AVG_RST <= 1'b1;
      PERT_EN <= 1'b0;
      PERT_SIGN <= 1'b0;
      J_PLUS <= '0;
      J_MINUS <= '0;
      DJ <= '0;
      DJ_VALID <= 1'b0;
      BUSY <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      ITER_COUNT <= '0;
    end else begin
      DJ_VALID <= 1'b0;
      if (state != IDLE && STOP) stop_q <= 1'b1;
      unique case (state)
        IDLE:
          if (START) begin
            state <= P_SETTLE;
            stop_q <= STOP;
            PERT_EN <= 1'b1;
            PERT_SIGN <= 1'b0;
            AVG_RST <= 1'b1;
            BUSY <= 1'b1;
            TIMEOUT_ERR <= 1'b0;
            ITER_COUNT <= '0;
          end
        P_SETTLE, M_SETTLE:
          if (tc) begin
            state <= state == P_SETTLE ? P_AVG : M_AVG;
            AVG_RST <= 1'b0;
          end
        P_AVG, M_AVG:
          if (AVG_DONE) begin
            if (state == P_AVG) J_PLUS <= AVG_DATA;
            else J_MINUS <= AVG_DATA;
            state <= state == P_AVG ? M_SETTLE : DIFF;
            PERT_EN <= state == P_AVG;
            PERT_SIGN <= state == P_AVG;
            AVG_RST <= 1'b1;
          end else if (tc) begin
            state <= IDLE;
            stop_q <= 1'b0;
            TIMEOUT_ERR <= 1'b1;
            PERT_EN <= 1'b0;
            PERT_SIGN <= 1'b0;
            AVG_RST <= 1'b1;
            BUSY <= 1'b0;
          end
        DIFF: begin
          DJ <= {J_PLUS[ADC_WIDTH], J_PLUS} - {J_MINUS[ADC_WIDTH], J_MINUS};
          DJ_VALID <= 1'b1;
          ITER_COUNT <= ITER_COUNT + ITER_W'(1);
          state <= stop_q ? IDLE : P_SETTLE;
          stop_q <= 1'b0;
          PERT_EN <= !stop_q;
          PERT_SIGN <= 1'b0;
          BUSY <= !stop_q;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spgd_dither_sequencer.sv
// tb_spgd_dither_sequencer: directed vectors plus multi-cycle corner sequences against a mock averager
module tb_spgd_dither_sequencer;
  localparam int AW = 12;
  logic clk = 1'b0, rst, start, stop;
  logic avg_rst, avg_done, pert_en, pert_sign, dj_valid, busy, terr;
  logic signed [AW:0] avg_data, j_plus, j_minus;
  logic signed [AW+1:0] dj;
  logic [15:0] iter;
  int n_cmp = 0, n_fail = 0;
  int delay = 8, pulses;
  logic mock_en = 1'b1, force_done = 1'b0, ok;
  logic signed [AW:0] data_p = '0, data_m = '0;
  logic [15:0] mcnt;
  typedef struct {
    logic signed [AW:0] jp;
    logic signed [AW:0] jm;
    logic signed [AW+1:0] dj;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  spgd_dither_sequencer #(.ADC_WIDTH(AW), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(4096)) dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop),
    .AVG_RST(avg_rst), .AVG_DONE(avg_done), .AVG_DATA(avg_data),
    .PERT_EN(pert_en), .PERT_SIGN(pert_sign),
    .J_PLUS(j_plus), .J_MINUS(j_minus), .DJ(dj), .DJ_VALID(dj_valid),
    .BUSY(busy), .TIMEOUT_ERR(terr), .ITER_COUNT(iter)
  );

  // mock averager: DONE on the delay-th cycle after its reset is released
  always @(posedge clk) mcnt <= avg_rst ? 16'd0 : mcnt + 16'd1;
  assign avg_done = force_done | (mock_en && !avg_rst && mcnt == 16'(delay - 1));
  assign avg_data = pert_sign ? data_m : data_p;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_until_idle(input int bound, output int p);
    p = 0;
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (dj_valid) p++;
      if (!busy) ok = 1'b1;
    end
    check("reached_idle", ok, 1);
  endtask

  task automatic wait_dj(input int bound);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!dj_valid && i < bound);
    check("dj_valid_seen", dj_valid, 1);
  endtask

  task automatic wait_m_avg(input int bound);
    int i = 0;
    do begin
      tick();
      i++;
    end while (!(pert_en && pert_sign && !avg_rst) && i < bound);
    check("m_avg_reached", pert_en && pert_sign && !avg_rst, 1);
  endtask

  initial begin
    vecs[0] = '{13'sh0F0, 13'sh010, 14'sh0E0};
    vecs[1] = '{13'sh0FFF, 13'sh1000, 14'sd8191};
    vecs[2] = '{13'sh1000, 13'sh0FFF, -14'sd8191};
    vecs[3] = '{-13'sd1, 13'sd1, -14'sd2};
    vecs[4] = '{13'sd55, -13'sd100, 14'sd155};
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    repeat (3) tick();
    check("rst_avg_rst", avg_rst, 1);
    check("rst_pert_en", pert_en, 0);
    check("rst_busy", busy, 0);
    check("rst_dj", dj, 0);
    check("rst_iter", iter, 0);
    check("rst_terr", terr, 0);
    check("rst_dj_valid", dj_valid, 0);
    rst = 1'b0;
    tick();
    // normal iteration, long window, spurious DONE during settle, STOP mid-iteration
    delay = 1024; data_p = 13'sh0F0; data_m = 13'sh010;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_pert_en", pert_en, 1);
    check("start_avg_rst", avg_rst, 1);
    check("start_sign", pert_sign, 0);
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    tick();
    check("spurious_j_plus", j_plus, 0);
    check("spurious_sign", pert_sign, 0);
    check("spurious_avg_rst", avg_rst, 1);
    tick();
    check("settle_avg_rst_hi", avg_rst, 1);
    tick();
    check("settle_avg_rst_lo", avg_rst, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_until_idle(3000, pulses);
    check("norm_pulses", pulses, 1);
    check("norm_dj", dj, 14'sh0E0);
    check("norm_iter", iter, 1);
    check("norm_j_plus", j_plus, 13'sh0F0);
    check("norm_j_minus", j_minus, 13'sh010);
    // table vectors, each with START and STOP in the same cycle
    delay = 8;
    for (int v = 0; v < 5; v++) begin
      data_p = vecs[v].jp; data_m = vecs[v].jm;
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      run_until_idle(200, pulses);
      check($sformatf("vec%0d_pulses", v), pulses, 1);
      check($sformatf("vec%0d_dj", v), dj, vecs[v].dj);
      check($sformatf("vec%0d_iter", v), iter, 1);
      check($sformatf("vec%0d_j_plus", v), j_plus, vecs[v].jp);
    end
    // timeout in P_AVG: entry edge a, error visible from edge a+4096
    mock_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("tmo_avg_rst_lo", avg_rst, 0);
    repeat (4095) tick();
    check("tmo_early_busy", busy, 1);
    check("tmo_early_terr", terr, 0);
    tick();
    check("tmo_terr", terr, 1);
    check("tmo_busy", busy, 0);
    check("tmo_pert_en", pert_en, 0);
    check("tmo_j_plus", j_plus, vecs[4].jp);
    check("tmo_iter", iter, 0);
    mock_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_clear_terr", terr, 0);
    check("tmo_restart_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    // STOP during iteration 3's M_SETTLE, START while busy ignored
    data_p = 13'sd20; data_m = 13'sd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dj(200);
    check("stop_iter1", iter, 1);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_busy", busy, 1);
    check("busy_start_iter", iter, 1);
    wait_dj(200);
    check("stop_iter2", iter, 2);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      ok = pert_sign && avg_rst;
    end
    check("m_settle_reached", ok, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run_until_idle(200, pulses);
    check("stop_pulses", pulses, 1);
    check("stop_iter3", iter, 3);
    check("stop_dj", dj, 15);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dj_valid || busy) pulses++;
    end
    check("stop_stays_idle", pulses, 0);
    // reset during M_AVG of iteration 2
    data_p = 13'sd77; data_m = 13'sd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_dj(200);
    wait_m_avg(100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_avg_rst", avg_rst, 1);
    check("mrst_pert_en", pert_en, 0);
    check("mrst_busy", busy, 0);
    check("mrst_j_plus", j_plus, 0);
    check("mrst_j_minus", j_minus, 0);
    check("mrst_dj", dj, 0);
    check("mrst_iter", iter, 0);
    check("mrst_dj_valid", dj_valid, 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dj_valid || busy) pulses++;
    end
    check("mrst_quiet", pulses, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
